hex_block: RTL and testbench

// - Eight-digit hexadecimal 7-segment display driver for the FP UART demo datapath.
// - Captures a 32-bit word (e.g. operand received by the UART Rx block) on an enable strobe.
// - Drives one 7-segment pattern per nibble; digit 0 is the least significant nibble.

---
 rtl/hex_block.sv | 99 +++++++++
 tb/tb_hex_block.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hex_block.sv
// Eight-digit hex 7-segment driver: captures a 32-bit word on i_hex_en and shows one digit per nibble.
// Optional macro HEX_LEADING_ZERO_BLANK_EN blanks leading zero digits, with digit 0 always shown.
module hex_block #(
  parameter int SIZE_HEX   = 7,
  parameter int SIZE_DATA  = 32,
  parameter int TYPE_ANODE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_hex_en,
  input  logic [SIZE_DATA-1:0] i_hex_data,
  output logic [SIZE_HEX-1:0]  o_hex_0,
  output logic [SIZE_HEX-1:0]  o_hex_1,
  output logic [SIZE_HEX-1:0]  o_hex_2,
  output logic [SIZE_HEX-1:0]  o_hex_3,
  output logic [SIZE_HEX-1:0]  o_hex_4,
  output logic [SIZE_HEX-1:0]  o_hex_5,
  output logic [SIZE_HEX-1:0]  o_hex_6,
  output logic [SIZE_HEX-1:0]  o_hex_7
);

  if (SIZE_HEX != 7 || SIZE_DATA != 32) begin : g_bad_params
    $error("hex_block: SIZE_HEX must be 7 and SIZE_DATA must be 32");
  end

  localparam logic [SIZE_HEX-1:0] BLANK = (TYPE_ANODE != 0) ? '1 : '0;

  // Segment code for one nibble. Codes are stored in cathode polarity and inverted for anode boards.
  function automatic logic [SIZE_HEX-1:0] enc(input logic [3:0] n);
    logic [SIZE_HEX-1:0] c;
    case (n)
      4'h0:    c = 7'h3F;
      4'h1:    c = 7'h06;
      4'h2:    c = 7'h5B;
      4'h3:    c = 7'h4F;
      4'h4:    c = 7'h66;
      4'h5:    c = 7'h6D;
      4'h6:    c = 7'h7D;
      4'h7:    c = 7'h07;
      4'h8:    c = 7'h7F;
      4'h9:    c = 7'h6F;
      4'hA:    c = 7'h77;
      4'hB:    c = 7'h7C;
      4'hC:    c = 7'h39;
      4'hD:    c = 7'h5E;
      4'hE:    c = 7'h79;
      4'hF:    c = 7'h71;
      default: c = '0;
    endcase
    return (TYPE_ANODE != 0) ? ~c : c;
  endfunction

  logic [SIZE_DATA-1:0]          data_d, data_q;
  logic [7:0][SIZE_HEX-1:0]      hex_d, hex_q;
`ifdef HEX_LEADING_ZERO_BLANK_EN
  logic                          zero_run;
`endif

  always_comb begin
    data_d = i_hex_en ? i_hex_data : data_q;
  end

  always_comb begin
    hex_d = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      hex_d[k] = enc(data_q[4*k +: 4]);
    end
`ifdef HEX_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; blanking stops at the first non-zero nibble and never reaches digit 0.
    zero_run = 1'b1;
    for (int unsigned k = 7; k >= 1; k--) begin
      zero_run = zero_run && (data_q[4*k +: 4] == 4'h0);
      if (zero_run) begin
        hex_d[k] = BLANK;
      end
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q <= '0;
      hex_q  <= {8{BLANK}};
    end else begin
      data_q <= data_d;
      hex_q  <= hex_d;
    end
  end

  assign o_hex_0 = hex_q[0];
  assign o_hex_1 = hex_q[1];
  assign o_hex_2 = hex_q[2];
  assign o_hex_3 = hex_q[3];
  assign o_hex_4 = hex_q[4];
  assign o_hex_5 = hex_q[5];
  assign o_hex_6 = hex_q[6];
  assign o_hex_7 = hex_q[7];

endmodule

// File: tb/tb_hex_block.sv
// Scoreboard bench for hex_block: anode and cathode instances share stimulus and are checked against a word-level model.
module tb_hex_block;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [31:0] data = '0;

  logic [6:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic [6:0] c0, c1, c2, c3, c4, c5, c6, c7;
  logic [7:0][6:0] dut_a, dut_c;

  always #5 clk = ~clk;

  hex_block #(.SIZE_HEX(7), .SIZE_DATA(32), .TYPE_ANODE(1)) u_anode (
    .i_clk(clk), .i_rst(rst), .i_hex_en(en), .i_hex_data(data),
    .o_hex_0(a0), .o_hex_1(a1), .o_hex_2(a2), .o_hex_3(a3),
    .o_hex_4(a4), .o_hex_5(a5), .o_hex_6(a6), .o_hex_7(a7)
  );

  hex_block #(.SIZE_HEX(7), .SIZE_DATA(32), .TYPE_ANODE(0)) u_cathode (
    .i_clk(clk), .i_rst(rst), .i_hex_en(en), .i_hex_data(data),
    .o_hex_0(c0), .o_hex_1(c1), .o_hex_2(c2), .o_hex_3(c3),
    .o_hex_4(c4), .o_hex_5(c5), .o_hex_6(c6), .o_hex_7(c7)
  );

  assign dut_a = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign dut_c = {c7, c6, c5, c4, c3, c2, c1, c0};

  typedef struct packed {
    logic [7:0][6:0] a;
    logic [7:0][6:0] c;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_word = '0;
  logic [6:0]  cath_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Display image of a whole captured word, in cathode polarity (1 = lit).
  function automatic logic [7:0][6:0] show_word(input logic [31:0] w);
    logic [7:0][6:0] r;
    int unsigned     top;
    top = 0;
    for (int i = 0; i < 8; i++) begin
      r[i] = cath_tab[(w >> (4 * i)) & 32'hF];
      if (((w >> (4 * i)) & 32'hF) != 0) top = i;
    end
`ifdef HEX_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < 8; i++) if (i > top) r[i] = 7'h00;
`endif
    return r;
  endfunction

  // One clock of stimulus; queue what both displays must show right after this edge.
  task automatic step(input logic r, input logic e, input logic [31:0] d);
    exp_t x;
    @(negedge clk);
    rst  = r;
    en   = e;
    data = d;
    if (r) begin
      x.c = '0;
      x.a = '1;
    end else begin
      x.c = show_word(model_word);
      x.a = ~x.c;
    end
    sb_q.push_back(x);
    if (r) model_word = '0;
    else if (e) model_word = d;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        checks++;
        if (dut_a !== x.a) begin
          errors++;
          $display("FAIL anode_digits: got %h expected %h", dut_a, x.a);
        end
        checks++;
        if (dut_c !== x.c) begin
          errors++;
          $display("FAIL cathode_digits: got %h expected %h", dut_c, x.c);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [7:0][6:0] want;
    logic [31:0]     w;
    repeat (3) step(1'b1, 1'b0, 32'h0);

    // Strobe then idle; anode pattern must appear two clocks after the strobe
    step(1'b0, 1'b1, 32'hC0B0C0A6);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    want = {7'h46, 7'h40, 7'h03, 7'h40, 7'h46, 7'h40, 7'h08, 7'h02};
    checks++;
    if (dut_a !== want) begin
      errors++;
      $display("FAIL capture_latency: got %h expected %h", dut_a, want);
    end

    step(1'b0, 1'b1, 32'h01234567);
    repeat (4) step(1'b0, 1'b0, 32'h89ABCDEF);
    step(1'b0, 1'b1, 32'h76543210);
    step(1'b0, 1'b1, 32'hFEDCBA98);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hFFFFFFFF);
    repeat (3) step(1'b0, 1'b0, 32'hFFFFFFFF);
    step(1'b0, 1'b1, 32'h000000A6);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h00000000);
    repeat (3) step(1'b0, 1'b0, 32'h12345678);
    step(1'b0, 1'b1, 32'hDEADBEEF);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    repeat (2) step(1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, $urandom);

    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(3) == 0) w = w >> (4 * $urandom_range(7));
      if ($urandom_range(15) == 0) w = '0;
      step($urandom_range(31) == 0, $urandom_range(1) == 1, w);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
